// File: rtl/or1200_if_queue.sv
//==============================================================================
// Module      : or1200_if_queue
// Description : Instruction-fetch stage with a DEPTH-entry return queue.
//               Fetch returns arriving while decode is frozen (or while older
//               entries are still waiting) are stored instead of refetched.
//               When the queue is empty and decode is running, a return
//               passes straight through with zero latency. The queue state
//               is exposed to the IC as backpressure (icpu_rdy_o), and a
//               return that arrives when the queue is full is dropped and
//               reported on genpc_refetch.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module or1200_if_queue #(
   parameter  int DEPTH = 2,
   parameter  int DW    = 32,
   parameter  int AW    = 32,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,

   // IC / IMMU CPU port
   input  logic [DW-1:0] icpu_dat_i,
   input  logic          icpu_ack_i,
   input  logic          icpu_err_i,
   input  logic [AW-1:0] icpu_adr_i,
   input  logic [3:0]    icpu_tag_i,
   output logic          icpu_rdy_o,

   // Pipeline control
   input  logic          if_freeze,
   input  logic          if_flushpipe,
   input  logic          no_more_dslot,
   input  logic          rfe,

   // Decode-side outputs
   output logic [DW-1:0] if_insn,
   output logic [AW-1:0] if_pc,
   output logic          if_stall,
   output logic          saving_if_insn,
   output logic          genpc_refetch,
   output logic [LW-1:0] if_level,
   output logic          except_itlbmiss,
   output logic          except_immufault,
   output logic          except_ibuserr
);

   //---------------------------------------------------------------------------
   // Constants
   //---------------------------------------------------------------------------
   // Pointer width; a single-entry queue still needs a 1-bit pointer.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // l.nop encodings: NOP0 marks killed/flushed slots, NOP1 marks idle.
   localparam logic [31:0] NOP0_32 = {6'b000101, 26'h041_0000};
   localparam logic [31:0] NOP1_32 = {6'b000101, 26'h061_0000};
   localparam logic [DW-1:0] NOP0  = DW'(NOP0_32);
   localparam logic [DW-1:0] NOP1  = DW'(NOP1_32);

   // Exception tag encodings presented by the IMMU/IC.
   localparam logic [3:0] TAG_TE = 4'hd;   // ITLB miss
   localparam logic [3:0] TAG_PE = 4'hc;   // IMMU page fault
   localparam logic [3:0] TAG_BE = 4'hb;   // bus error

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);

   //---------------------------------------------------------------------------
   // Queue storage and control state
   //---------------------------------------------------------------------------
   logic [DW-1:0] insn_q [DEPTH];
   logic [AW-1:0] pc_q   [DEPTH];
   logic [2:0]    err_q  [DEPTH];   // {BE, PE, TE}

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] count_q,  count_d;
   logic          bypass_q, bypass_d;

   //---------------------------------------------------------------------------
   // Combinational helpers
   //---------------------------------------------------------------------------
   logic          ret;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          if_bypass;
   logic [AW-1:0] adr_aligned;
   logic [2:0]    ret_err;
   logic [DW-1:0] ret_insn;
   logic [DW-1:0] head_insn;
   logic [AW-1:0] head_pc;
   logic [2:0]    head_err;

   // Address bit 1 has no meaning for word-aligned fetches; keep lint quiet.
   logic          unused_adr;
   assign unused_adr = icpu_adr_i[1];

   // Wrap-around pointer increment; works for any DEPTH, not just powers of 2.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // Classify the current return and derive queue handshakes.
   always_comb begin
      ret         = icpu_ack_i | icpu_err_i;
      empty       = (count_q == '0);
      full        = (count_q == LVL_FULL);
      adr_aligned = {icpu_adr_i[AW-1:2], 2'b00};

      ret_err[0]  = icpu_err_i & (icpu_tag_i == TAG_TE);
      ret_err[1]  = icpu_err_i & (icpu_tag_i == TAG_PE);
      ret_err[2]  = icpu_err_i & (icpu_tag_i == TAG_BE);
      ret_insn    = icpu_err_i ? NOP0 : icpu_dat_i;

      // A return is stored only when it cannot pass straight to decode:
      // either decode is frozen or older entries must drain first.
      push        = ret & ~if_flushpipe & ~full & (if_freeze | ~empty);
      pop         = ~if_freeze & ~empty & ~if_flushpipe;

      // Once a flush is seen, keep killing the slot until the fetch of the
      // new target is signalled by address bit 0.
      if_bypass   = icpu_adr_i[0] ? 1'b0 : (bypass_q | if_flushpipe);
   end

   // Head-of-queue read port.
   always_comb begin
      head_insn = insn_q[rd_ptr_q];
      head_pc   = pc_q[rd_ptr_q];
      head_err  = err_q[rd_ptr_q];
   end

   //---------------------------------------------------------------------------
   // Next-state computation for pointers, occupancy and bypass flag
   //---------------------------------------------------------------------------
   // Flush empties the queue outright and outranks any same-cycle push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      bypass_d = if_bypass;

      if (if_flushpipe) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         // push is blocked when full and pop when empty, so the counter
         // can never leave the range 0..DEPTH.
         case ({push, pop})
            2'b10:   count_d = count_q + LVL_ONE;
            2'b01:   count_d = count_q - LVL_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   // Control state with synchronous reset; reset outranks flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         bypass_q <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         bypass_q <= bypass_d;
      end
   end

   // Entry payload; only the occupancy counter says which entries are valid,
   // so the data array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         insn_q[wr_ptr_q] <= ret_insn;
         pc_q[wr_ptr_q]   <= adr_aligned;
         err_q[wr_ptr_q]  <= ret_err;
      end
   end

   //---------------------------------------------------------------------------
   // Decode-side outputs
   //---------------------------------------------------------------------------
   // Select instruction, pc and exception flags presented to decode.
   always_comb begin
      if (no_more_dslot | rfe | if_bypass) begin
         if_insn = NOP0;
      end else if (!empty) begin
         if_insn = head_insn;
      end else if (icpu_ack_i) begin
         if_insn = icpu_dat_i;
      end else begin
         if_insn = NOP1;
      end

      if_pc = empty ? adr_aligned : head_pc;

      if (no_more_dslot) begin
         except_itlbmiss  = 1'b0;
         except_immufault = 1'b0;
         except_ibuserr   = 1'b0;
      end else if (!empty) begin
         except_itlbmiss  = head_err[0];
         except_immufault = head_err[1];
         except_ibuserr   = head_err[2];
      end else begin
         except_itlbmiss  = ret_err[0];
         except_immufault = ret_err[1];
         except_ibuserr   = ret_err[2];
      end
   end

   // Status outputs toward decode, genpc and the IC.
   always_comb begin
      if_stall       = empty & ~ret;
      saving_if_insn = push;
      genpc_refetch  = ret & full & ~if_flushpipe;
      icpu_rdy_o     = ~full;
      if_level       = count_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_or1200_if_queue.sv
//==============================================================================
// Module      : tb_or1200_if_queue
// Description : Self-checking bench for or1200_if_queue. Directed scenarios
//               followed by randomized traffic, all compared against a
//               queue-based reference model of the fetch stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_or1200_if_queue;

   localparam int DEPTH = 2;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int LW    = $clog2(DEPTH + 1);

   localparam logic [31:0] NOP0 = {6'b000101, 26'h041_0000};
   localparam logic [31:0] NOP1 = {6'b000101, 26'h061_0000};

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] icpu_dat_i;
   logic          icpu_ack_i;
   logic          icpu_err_i;
   logic [AW-1:0] icpu_adr_i;
   logic [3:0]    icpu_tag_i;
   logic          icpu_rdy_o;
   logic          if_freeze;
   logic          if_flushpipe;
   logic          no_more_dslot;
   logic          rfe;
   logic [DW-1:0] if_insn;
   logic [AW-1:0] if_pc;
   logic          if_stall;
   logic          saving_if_insn;
   logic          genpc_refetch;
   logic [LW-1:0] if_level;
   logic          except_itlbmiss;
   logic          except_immufault;
   logic          except_ibuserr;

   int n_tests = 0;
   int n_fail  = 0;

   or1200_if_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .icpu_dat_i       (icpu_dat_i),
      .icpu_ack_i       (icpu_ack_i),
      .icpu_err_i       (icpu_err_i),
      .icpu_adr_i       (icpu_adr_i),
      .icpu_tag_i       (icpu_tag_i),
      .icpu_rdy_o       (icpu_rdy_o),
      .if_freeze        (if_freeze),
      .if_flushpipe     (if_flushpipe),
      .no_more_dslot    (no_more_dslot),
      .rfe              (rfe),
      .if_insn          (if_insn),
      .if_pc            (if_pc),
      .if_stall         (if_stall),
      .saving_if_insn   (saving_if_insn),
      .genpc_refetch    (genpc_refetch),
      .if_level         (if_level),
      .except_itlbmiss  (except_itlbmiss),
      .except_immufault (except_immufault),
      .except_ibuserr   (except_ibuserr)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue of stored returns plus the bypass flag.
   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc;
      logic [2:0]  err;   // {BE, PE, TE}
   } ent_t;

   ent_t mq[$];
   logic mbyp = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle's inputs and let combinational outputs settle.
   task automatic drv(input logic ack, input logic err, input logic [31:0] dat,
                      input logic [31:0] adr, input logic [3:0] tag,
                      input logic frz, input logic fl, input logic nmd, input logic rf);
      icpu_ack_i    = ack;
      icpu_err_i    = err;
      icpu_dat_i    = dat;
      icpu_adr_i    = adr;
      icpu_tag_i    = tag;
      if_freeze     = frz;
      if_flushpipe  = fl;
      no_more_dslot = nmd;
      rfe           = rf;
      #1;
   endtask

   // Compare all outputs with the model, advance the model, move one cycle on.
   task automatic tick();
      logic        ret, empty, full, byp, push, pop;
      logic [2:0]  eerr, exp_exc;
      logic [31:0] exp_insn, exp_pc;
      ent_t        e;
      ret   = icpu_ack_i | icpu_err_i;
      empty = (mq.size() == 0);
      full  = (mq.size() == DEPTH);
      byp   = icpu_adr_i[0] ? 1'b0 : (mbyp | if_flushpipe);
      push  = ret & !if_flushpipe & !full & (if_freeze | !empty);
      pop   = !if_freeze & !empty & !if_flushpipe;
      eerr  = {icpu_err_i && icpu_tag_i == 4'hb,
               icpu_err_i && icpu_tag_i == 4'hc,
               icpu_err_i && icpu_tag_i == 4'hd};
      if (!rst) begin
         if (no_more_dslot | rfe | byp) exp_insn = NOP0;
         else if (!empty)               exp_insn = mq[0].insn;
         else if (icpu_ack_i)           exp_insn = icpu_dat_i;
         else                           exp_insn = NOP1;
         exp_pc  = !empty ? mq[0].pc : {icpu_adr_i[31:2], 2'b00};
         exp_exc = no_more_dslot ? 3'b000 : (!empty ? mq[0].err : eerr);
         check("insn",    64'(if_insn), 64'(exp_insn));
         check("pc",      64'(if_pc), 64'(exp_pc));
         check("level",   64'(if_level), 64'(mq.size()));
         check("rdy",     64'(icpu_rdy_o), 64'(!full));
         check("stall",   64'(if_stall), 64'(empty & !ret));
         check("saving",  64'(saving_if_insn), 64'(push));
         check("refetch", 64'(genpc_refetch), 64'(ret & full & !if_flushpipe));
         check("except",  64'({except_ibuserr, except_immufault, except_itlbmiss}), 64'(exp_exc));
      end
      if (rst) begin
         mq.delete();
         mbyp = 1'b0;
      end else begin
         if (if_flushpipe) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
               e.insn = icpu_err_i ? NOP0 : icpu_dat_i;
               e.pc   = {icpu_adr_i[31:2], 2'b00};
               e.err  = eerr;
               mq.push_back(e);
            end
         end
         mbyp = byp;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      drv(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
      check("rst_level", 64'(if_level), 64'd0);
      check("rst_rdy", 64'(icpu_rdy_o), 64'd1);
      check("rst_insn", 64'(if_insn), 64'(NOP1));
      tick();

      // Pass-through with zero latency
      drv(1, 0, 32'h1234_5678, 32'h100, 0, 0, 0, 0, 0);
      check("pass_insn", 64'(if_insn), 64'h1234_5678);
      check("pass_pc", 64'(if_pc), 64'h100);
      tick();
      check("pass_level", 64'(if_level), 64'd0);

      // Fill under freeze, overflow, then drain
      drv(1, 0, 32'hA, 32'h200, 0, 1, 0, 0, 0);
      tick();
      check("fill_lvl1", 64'(if_level), 64'd1);
      drv(1, 0, 32'hB, 32'h204, 0, 1, 0, 0, 0);
      tick();
      check("fill_lvl2", 64'(if_level), 64'd2);
      check("fill_rdy", 64'(icpu_rdy_o), 64'd0);
      drv(1, 0, 32'hC, 32'h208, 0, 1, 0, 0, 0);
      check("ovf_refetch", 64'(genpc_refetch), 64'd1);
      tick();
      check("ovf_level", 64'(if_level), 64'd2);
      drv(0, 0, 0, 32'h20c, 0, 0, 0, 0, 0);
      check("drain_a", 64'(if_insn), 64'hA);
      tick();
      check("drain_b", 64'(if_insn), 64'hB);
      check("drain_lvl", 64'(if_level), 64'd1);
      tick();
      check("drain_empty", 64'(if_level), 64'd0);

      // Flush a full queue; bypass holds NOP0 until adr bit0 is seen
      drv(1, 0, 32'h11, 32'h300, 0, 1, 0, 0, 0);
      tick();
      drv(1, 0, 32'h22, 32'h304, 0, 1, 0, 0, 0);
      tick();
      drv(0, 0, 0, 32'h308, 0, 1, 1, 0, 0);
      tick();
      drv(0, 0, 0, 32'h400, 0, 1, 0, 0, 0);
      check("flush_level", 64'(if_level), 64'd0);
      check("flush_nop0", 64'(if_insn), 64'(NOP0));
      tick();
      drv(0, 0, 0, 32'h401, 0, 0, 0, 0, 0);
      check("bypass_clr", 64'(if_insn), 64'(NOP1));
      tick();

      // Error return stored under freeze
      drv(0, 1, 32'hdead, 32'h500, 4'hd, 1, 0, 0, 0);
      tick();
      drv(0, 0, 0, 32'h504, 0, 1, 0, 0, 0);
      check("err_level", 64'(if_level), 64'd1);
      check("err_insn", 64'(if_insn), 64'(NOP0));
      check("err_te", 64'(except_itlbmiss), 64'd1);
      tick();
      drv(0, 0, 0, 32'h504, 0, 1, 0, 1, 0);
      check("nmd_exc", 64'({except_ibuserr, except_immufault, except_itlbmiss}), 64'd0);
      tick();
      drv(0, 0, 0, 32'h504, 0, 0, 0, 0, 0);
      tick();

      // Simultaneous push and pop
      drv(1, 0, 32'hD, 32'h600, 0, 1, 0, 0, 0);
      tick();
      drv(1, 0, 32'hE, 32'h604, 0, 0, 0, 0, 0);
      check("pp_head", 64'(if_insn), 64'hD);
      tick();
      drv(0, 0, 0, 32'h608, 0, 0, 0, 0, 0);
      check("pp_level", 64'(if_level), 64'd1);
      check("pp_next", 64'(if_insn), 64'hE);
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] adr;
         logic [3:0]  tg;
         logic        a, er;
         adr    = $urandom;
         adr[0] = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0: tg = 4'hd;
            1: tg = 4'hc;
            2: tg = 4'hb;
            default: tg = 4'(($urandom_range(0, 10)));
         endcase
         a  = ($urandom_range(0, 99) < 50);
         er = ($urandom_range(0, 99) < 12);
         rst = ($urandom_range(0, 199) == 0);
         drv(a, er, $urandom, adr, tg,
             ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 99) < 5),
             ($urandom_range(0, 99) < 8),
             ($urandom_range(0, 99) < 8));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
